seq_alu: RTL and testbench
==========================

// Module: seq_alu
// PURPOSE
//   Handshaked, registered N-bit ALU for the UART calculator datapath. It sits between
//   the command parser (operand/opcode source) and the result formatter (sink).
//   It adds flags (Z/N/C/V), compare ops and range-checked shifts. It also has an
//   optional iterative multiplier and an error flag for illegal opcodes.
// PARAMETERS
//   N      8   operand/result width, N >= 2
//   SHW    $clog2(N)  derived, localparam: shift-amount field width
// PORTS
//   clk        in   1    clock, rising edge
//   rst        in   1    asynchronous, active-high reset
//   in_valid   in   1    operand/opcode presented
//   in_ready   out  1    ALU can accept (high only in IDLE)
//   op         in   4    opcode
//   a, b       in   N    operands (unsigned unless op says signed)
//   out_valid  out  1    result registers valid
//   out_ready  in   1    sink accepts result
//   y          out  N    result (mul: low half)
//   y_hi       out  N    mul high half; 0 for all other ops
//   flg_z/n/c/v out 1 each  zero, negative (y[N-1]), carry/no-borrow, signed overflow
//   err        out  1    illegal/disabled opcode
// BEHAVIOUR
//   Reset: state=IDLE, in_ready=1, out_valid=0, y=y_hi=0, all flags=0, err=0.
//   FSM IDLE -> (in_valid) capture a,b,op -> EXEC | MUL; EXEC -> DONE (1 cycle);
//     MUL -> DONE after N iterations; DONE -> (out_ready) IDLE.
//   Transfer happens only when valid&&ready on the same rising edge. in_ready=0 outside IDLE.
//   Inputs change freely after capture.
//   Latency: accept at edge k -> out_valid high after edge k+2 (non-mul), k+N+2 (mul).
//   out_valid and all outputs stay stable in DONE until out_ready; no bubble-free overlap.
//   Ops: 0 add, 1 sub (a-b), 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 mul (macro),
//     9 slt (signed, y=1/0), 10 sltu (unsigned, y=1/0), 11 eq (y = a==b).
//     12-15 are illegal: y=0, flags=0, err=1, EXEC path.
//   add/sub: computed at N+1 bits. c=carry out (sub: c=1 means no borrow, a>=b unsigned).
//     v = signed overflow. All arithmetic wraps mod 2^N.
//   Shifts: amount = b as unsigned. If b >= N: sll/srl give 0, sra gives {N{a[N-1]}}.
//     c = last bit shifted out (0 if b==0; for b>=N, sll/srl c=0, sra c=a[N-1]).
//   flg_z = (y==0) && (y_hi==0). flg_n = y[N-1]. v=0 and c=0 for logic/compare ops.
//   Reset mid-operation: aborts the op immediately and returns all outputs to reset values.
//   out_ready while out_valid=0 is ignored. in_valid during a busy period is not captured.
// CONFIGURATION
//   SEQ_ALU_MUL_EN defined: op 8 = unsigned mul, shift-add over N cycles in state MUL.
//     {y_hi,y}=a*b; c=v=(y_hi!=0); err=0.
//   Undefined: no multiplier logic; op 8 is illegal (y=0, y_hi=0, err=1) on the 1-cycle path.
// TESTING (N=8)
//   add a=8'hF0,b=8'h20 -> y=8'h10, c=1, v=0, z=0; out_valid 2 cycles after accept.
//   sub a=8'h80,b=8'h01 -> y=8'h7F, v=1, c=1, n=0. Then sub a=5,b=5 -> y=0, z=1, c=1.
//   sra a=8'h90,b=3 -> y=8'hF2, c=0. Then sra b=9 -> y=8'hFF. Then sll a=8'h81,b=8 -> y=0.
//   out_ready held 0 for 5 cycles -> y/flags stable, in_ready=0, new in_valid ignored.
//     out_ready=1 -> IDLE next cycle.
//   MUL_EN: a=8'hFF,b=8'hFF -> y_hi=8'hFE, y=8'h01, c=v=1, latency 10.
//     No MUL_EN: same op -> err=1, y=0.
//   rst pulse mid-MUL (cycle 4) -> out_valid=0, in_ready=1 immediately.
//     Next op slt a=8'hFF,b=1 -> y=1.

Source files
------------

// File: rtl/seq_alu.sv
// Handshaked, registered N-bit ALU with Z/N/C/V flags, compares and range-checked shifts.
// Define SEQ_ALU_MUL_EN to build the iterative shift-add multiplier for op 8.
module seq_alu #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] y,
  output logic [N-1:0] y_hi,
  output logic         flg_z,
  output logic         flg_n,
  output logic         flg_c,
  output logic         flg_v,
  output logic         err
);

  localparam int SHW = $clog2(N);
  localparam logic [N-1:0] LP_N = N[N-1:0];

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

  state_t       r_state;
  logic [3:0]   r_op;
  logic [N-1:0] r_a;
  logic [N-1:0] r_b;
  logic [N-1:0] r_y;
  logic [N-1:0] r_y_hi;
  logic         r_z;
  logic         r_n;
  logic         r_c;
  logic         r_v;
  logic         r_err;
  logic         r_out_valid;
  logic         r_in_ready;

`ifdef SEQ_ALU_MUL_EN
  logic [N-1:0]   r_mhi;
  logic [N-1:0]   r_mlo;
  logic [SHW-1:0] r_cnt;
  logic [N:0]     w_madd;
`endif

  logic [N:0]     w_sum;
  logic [N:0]     w_dif;
  logic [N:0]     w_shl;
  logic [N:0]     w_shr;
  logic [N:0]     w_sra;
  logic [SHW-1:0] w_sh;
  logic           w_big;
  logic [N-1:0]   w_y;
  logic [N-1:0]   w_y_hi;
  logic           w_c;
  logic           w_v;
  logic           w_err;
  logic           w_z;
  logic           w_n;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign y_hi      = r_y_hi;
  assign flg_z     = r_z;
  assign flg_n     = r_n;
  assign flg_c     = r_c;
  assign flg_v     = r_v;
  assign err       = r_err;

`ifdef SEQ_ALU_MUL_EN
  // One shift-add step: add multiplicand to the high half when the multiplier LSB is set.
  assign w_madd = {1'b0, r_mhi} + (r_mlo[0] ? {1'b0, r_a} : {(N+1){1'b0}});
`endif

  // Result and flag computation from the captured operands.
  always_comb begin
    w_sum  = {1'b0, r_a} + {1'b0, r_b};
    w_dif  = {1'b0, r_a} + {1'b0, ~r_b} + {{N{1'b0}}, 1'b1};
    w_big  = (r_b >= LP_N);
    w_sh   = r_b[SHW-1:0];
    // The extra guard bit on each shift catches the last bit shifted out.
    w_shl  = {1'b0, r_a} << w_sh;
    w_shr  = {r_a, 1'b0} >> w_sh;
    w_sra  = $signed({r_a, 1'b0}) >>> w_sh;
    w_y    = {N{1'b0}};
    w_y_hi = {N{1'b0}};
    w_c    = 1'b0;
    w_v    = 1'b0;
    w_err  = 1'b0;
    case (r_op)
      4'd0: begin
        w_y = w_sum[N-1:0];
        w_c = w_sum[N];
        w_v = (r_a[N-1] == r_b[N-1]) && (w_sum[N-1] != r_a[N-1]);
      end
      4'd1: begin
        w_y = w_dif[N-1:0];
        w_c = w_dif[N];
        w_v = (r_a[N-1] != r_b[N-1]) && (w_dif[N-1] != r_a[N-1]);
      end
      4'd2: w_y = r_a & r_b;
      4'd3: w_y = r_a | r_b;
      4'd4: w_y = r_a ^ r_b;
      4'd5: begin
        if (w_big) begin
          w_y = {N{1'b0}};
          w_c = 1'b0;
        end else begin
          w_y = w_shl[N-1:0];
          w_c = w_shl[N];
        end
      end
      4'd6: begin
        if (w_big) begin
          w_y = {N{1'b0}};
          w_c = 1'b0;
        end else begin
          w_y = w_shr[N:1];
          w_c = w_shr[0];
        end
      end
      4'd7: begin
        if (w_big) begin
          w_y = {N{r_a[N-1]}};
          w_c = r_a[N-1];
        end else begin
          w_y = w_sra[N:1];
          w_c = w_sra[0];
        end
      end
`ifdef SEQ_ALU_MUL_EN
      4'd8: begin
        w_y    = r_mlo;
        w_y_hi = r_mhi;
        w_c    = |r_mhi;
        w_v    = |r_mhi;
      end
`else
      4'd8: w_err = 1'b1;
`endif
      4'd9:  w_y = {{(N-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
      4'd10: w_y = {{(N-1){1'b0}}, (r_a < r_b)};
      4'd11: w_y = {{(N-1){1'b0}}, (r_a == r_b)};
      default: w_err = 1'b1;
    endcase
    w_z = !w_err && (w_y == {N{1'b0}}) && (w_y_hi == {N{1'b0}});
    w_n = !w_err && w_y[N-1];
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= 4'd0;
      r_a         <= {N{1'b0}};
      r_b         <= {N{1'b0}};
      r_y         <= {N{1'b0}};
      r_y_hi      <= {N{1'b0}};
      r_z         <= 1'b0;
      r_n         <= 1'b0;
      r_c         <= 1'b0;
      r_v         <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
`ifdef SEQ_ALU_MUL_EN
      r_mhi       <= {N{1'b0}};
      r_mlo       <= {N{1'b0}};
      r_cnt       <= {SHW{1'b0}};
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= b;
            r_op       <= op;
            r_in_ready <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            if (op == 4'd8) begin
              r_mhi   <= {N{1'b0}};
              r_mlo   <= b;
              r_cnt   <= {SHW{1'b0}};
              r_state <= S_MUL;
            end else begin
              r_state <= S_EXEC;
            end
`else
            r_state    <= S_EXEC;
`endif
          end
        end
        S_EXEC: begin
          r_y     <= w_y;
          r_y_hi  <= w_y_hi;
          r_z     <= w_z;
          r_n     <= w_n;
          r_c     <= w_c;
          r_v     <= w_v;
          r_err   <= w_err;
          r_state <= S_DONE;
        end
        S_MUL: begin
`ifdef SEQ_ALU_MUL_EN
          {r_mhi, r_mlo} <= {w_madd, r_mlo[N-1:1]};
          r_cnt          <= r_cnt + {{(SHW-1){1'b0}}, 1'b1};
          if (r_cnt == SHW'(N - 1)) begin
            r_state <= S_EXEC;
          end
`else
          r_state    <= S_IDLE;
          r_in_ready <= 1'b1;
`endif
        end
        S_DONE: begin
          // out_valid rises one cycle after the result registers load, so out_ready is ignored until then.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (N=8): directed spec cases, stall, reset abort, random ops.
module tb_seq_alu;

  localparam int N = 8;
`ifdef SEQ_ALU_MUL_EN
  localparam int MUL_LAT = N + 2;
`else
  localparam int MUL_LAT = 2;
`endif

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] yhi;
    logic       z;
    logic       n;
    logic       c;
    logic       v;
    logic       err;
  } res_t;

  typedef struct packed {
    res_t       r;
    logic [3:0] op;
    int         acc;
    int         lat;
  } item_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] op = 4'd0;
  logic [7:0] a = 8'd0;
  logic [7:0] b = 8'd0;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic [7:0] y_hi;
  logic       flg_z, flg_n, flg_c, flg_v, err;

  logic       rdy_rand = 1'b0;
  logic       rdy_man = 1'b1;
  logic       rnd_rdy = 1'b1;
  assign out_ready = rdy_rand ? rnd_rdy : rdy_man;

  item_t sb[$];
  int    cyc = 0;
  int    n_vec = 0;
  int    n_miss = 0;
  logic  seen = 1'b0;

  seq_alu #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .y(y), .y_hi(y_hi),
    .flg_z(flg_z), .flg_n(flg_n), .flg_c(flg_c), .flg_v(flg_v), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1 rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  function automatic res_t model(input logic [3:0] f_op, input logic [7:0] fa, input logic [7:0] fb);
    res_t e;
    int ua, ub, sa, sb_, r;
    e = '0;
    ua = int'(fa);
    ub = int'(fb);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb_ = (ub >= 128) ? ub - 256 : ub;
    case (f_op)
      4'd0: begin r = ua + ub; e.y = 8'(r); e.c = (r > 255); r = sa + sb_; e.v = (r > 127) || (r < -128); end
      4'd1: begin r = ua - ub; e.y = 8'(r); e.c = (ua >= ub); r = sa - sb_; e.v = (r > 127) || (r < -128); end
      4'd2: e.y = fa & fb;
      4'd3: e.y = fa | fb;
      4'd4: e.y = fa ^ fb;
      4'd5: if (ub < 8) begin r = ua << ub; e.y = 8'(r); e.c = (ub != 0) && (((r >> 8) & 1) == 1); end
      4'd6: if (ub < 8) begin e.y = 8'(ua >> ub); e.c = (ub != 0) && (((ua >> (ub - 1)) & 1) == 1); end
      4'd7: begin
        if (ub >= 8) begin
          e.y = (sa < 0) ? 8'hFF : 8'h00;
          e.c = (sa < 0);
        end else begin
          e.y = 8'(sa >>> ub);
          e.c = (ub != 0) && (((ua >> (ub - 1)) & 1) == 1);
        end
      end
`ifdef SEQ_ALU_MUL_EN
      4'd8: begin r = ua * ub; e.y = 8'(r); e.yhi = 8'(r >> 8); e.c = (e.yhi != 8'd0); e.v = e.c; end
`endif
      4'd9:  e.y = (sa < sb_) ? 8'd1 : 8'd0;
      4'd10: e.y = (ua < ub) ? 8'd1 : 8'd0;
      4'd11: e.y = (ua == ub) ? 8'd1 : 8'd0;
      default: e.err = 1'b1;
    endcase
    e.z = !e.err && (e.y == 8'd0) && (e.yhi == 8'd0);
    e.n = !e.err && e.y[7];
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: latency on first out_valid, result compare on each transfer.
  always @(negedge clk) begin
    if (rst) begin
      seen = 1'b0;
    end else begin
      if (out_valid && !seen) begin
        seen = 1'b1;
        n_vec++;
        if (sb.size() == 0) begin
          n_miss++;
          $display("FAIL unexpected_output: got out_valid at cycle %0d with empty scoreboard", cyc);
        end else if (cyc - sb[0].acc != sb[0].lat) begin
          n_miss++;
          $display("FAIL latency op=%0d: got %0d expected %0d", sb[0].op, cyc - sb[0].acc, sb[0].lat);
        end
      end
      if (out_valid && out_ready && sb.size() > 0) begin
        item_t it;
        res_t act;
        it = sb.pop_front();
        act = {y, y_hi, flg_z, flg_n, flg_c, flg_v, err};
        n_vec++;
        if (act !== it.r) begin
          n_miss++;
          $display("FAIL result op=%0d: got y=%h y_hi=%h zncv=%b%b%b%b err=%b expected y=%h y_hi=%h zncv=%b%b%b%b err=%b",
                   it.op, act.y, act.yhi, act.z, act.n, act.c, act.v, act.err,
                   it.r.y, it.r.yhi, it.r.z, it.r.n, it.r.c, it.r.v, it.r.err);
        end
        seen = 1'b0;
      end
    end
  end

  task automatic issue(input logic [3:0] t_op, input logic [7:0] ta, input logic [7:0] tb);
    item_t it;
    int t;
    t = 0;
    while (!in_ready && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      in_valid = 1'b1;
      op = t_op;
      a = ta;
      b = tb;
      it.r = model(t_op, ta, tb);
      it.op = t_op;
      it.acc = cyc + 1;
      it.lat = (t_op == 4'd8) ? MUL_LAT : 2;
      sb.push_back(it);
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    res_t snap;
    int t;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_y_yhi", {16'd0, y, y_hi}, 32'd0);
    chk("rst_flags_err", {27'd0, flg_z, flg_n, flg_c, flg_v, err}, 32'd0);

    issue(4'd0, 8'hF0, 8'h20);
    issue(4'd1, 8'h80, 8'h01);
    issue(4'd1, 8'h05, 8'h05);
    issue(4'd7, 8'h90, 8'h03);
    issue(4'd7, 8'h90, 8'h09);
    issue(4'd5, 8'h81, 8'h08);
    issue(4'd5, 8'h81, 8'h00);
    issue(4'd6, 8'h81, 8'h07);
    issue(4'd8, 8'hFF, 8'hFF);
    issue(4'd8, 8'h0C, 8'h0B);
    issue(4'd9, 8'hFF, 8'h01);
    issue(4'd10, 8'hFF, 8'h01);
    issue(4'd11, 8'h3C, 8'h3C);
    for (int i = 12; i < 16; i++) issue(4'(i), 8'h12, 8'h34);
    drain();

    // Backpressure: outputs frozen, busy, new request ignored.
    rdy_man = 1'b0;
    issue(4'd1, 8'h80, 8'h01);
    t = 0;
    while (!out_valid && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("stall_valid", 32'(out_valid), 32'd1);
    snap = {y, y_hi, flg_z, flg_n, flg_c, flg_v, err};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_hold", 32'({y, y_hi, flg_z, flg_n, flg_c, flg_v, err}), 32'(snap));
      chk("stall_busy", {30'd0, in_ready, out_valid}, 32'd1);
      in_valid = 1'b1;
      op = 4'd3;
      a = 8'($urandom);
      b = 8'($urandom);
    end
    in_valid = 1'b0;
    rdy_man = 1'b1;
    @(posedge clk); #1;
    chk("stall_release", {30'd0, in_ready, out_valid}, 32'd2);
    drain();

    // Reset in the middle of a (possibly multi-cycle) op.
    rdy_man = 1'b0;
    issue(4'd8, 8'hFF, 8'hFF);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mid_y", {16'd0, y, y_hi}, 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    rdy_man = 1'b1;
    issue(4'd9, 8'hFF, 8'h01);
    drain();

    rdy_rand = 1'b1;
    for (int i = 0; i < 150; i++) begin
      logic [3:0] rop;
      logic [7:0] ra, rb;
      rop = 4'($urandom_range(0, 15));
      ra = 8'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom);
      issue(rop, ra, rb);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    drain();
    rdy_rand = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
